// File: rtl/ddr_cmd_monitor_pkg.sv
// ddr_cmd_monitor_pkg: shared DDR command encodings, init FSM states and default timings
package ddr_cmd_monitor_pkg;
    localparam int T_RP = 3;
    localparam int T_MRD = 2;
    localparam int T_RFC = 11;
    localparam int T_RCD = 2;
    typedef enum logic [2:0] {
        CMD_LMR = 3'b000,
        CMD_AR  = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_BST = 3'b110,
        CMD_NOP = 3'b111
    } cmd_t;
    typedef enum logic [3:0] {
        S_WAIT_CKE, S_PRE0, S_EMRS, S_MRS0, S_PRE1, S_AR0, S_AR1, S_MRS1, S_READY, S_FAIL
    } state_t;
    function automatic logic [3:0] req_gap(cmd_t c, int trp, int tmrd, int trfc, int trcd);
        return c == CMD_PRE ? 4'(trp) : c == CMD_LMR ? 4'(tmrd) :
               c == CMD_AR ? 4'(trfc) : c == CMD_ACT ? 4'(trcd) : 4'd1;
    endfunction
endpackage

// File: rtl/ddr_cmd_monitor_gap_checker.sv
// ddr_gap_checker: tracks edges since the last command and flags commands issued too early
module ddr_gap_checker import ddr_cmd_monitor_pkg::*; #(
    parameter int tRP = T_RP,
    parameter int tMRD = T_MRD,
    parameter int tRFC = T_RFC,
    parameter int tRCD = T_RCD
) (
    input  logic clk133_p,
    input  logic rst,
    input  logic fire,
    input  cmd_t cmd,
    output logic viol
);
    logic [3:0] gap, req;
    always_ff @(posedge clk133_p) begin
        if (rst) begin
            gap <= 4'd15;
            req <= 4'd1;
        end else begin
            gap <= fire ? 4'd1 : gap == 4'd15 ? gap : gap + 4'd1;
            req <= fire ? req_gap(cmd, tRP, tMRD, tRFC, tRCD) : req;
        end
    end
    assign viol = fire && gap < req;
endmodule

// File: rtl/ddr_cmd_monitor.sv
// ddr_cmd_monitor: passive DDR command-bus monitor checking init order, bank use and command spacing
module ddr_cmd_monitor import ddr_cmd_monitor_pkg::*; #(
    parameter int tRP = T_RP,
    parameter int tMRD = T_MRD,
    parameter int tRFC = T_RFC,
    parameter int tRCD = T_RCD
) (
    input  logic        clk133_p,
    input  logic        rst,
    input  logic        sd_CKE,
    input  logic        sd_CS,
    input  logic        sd_RAS,
    input  logic        sd_CAS,
    input  logic        sd_WE,
    input  logic [12:0] sd_A,
    input  logic [1:0]  sd_BA,
    output logic        cmdValid,
    output logic [2:0]  cmdCode,
    output logic        initDone,
    output logic [12:0] modeReg,
    output logic [12:0] extModeReg,
    output logic [3:0]  bankOpen,
    output logic        errTiming,
    output logic        errSequence,
    output logic [7:0]  errCount
);
    state_t state, state_n;
    cmd_t cmd;
    logic cke_q, fire, viol, exp_ok, seq_bad, cke_fall, init_st;
    logic [3:0] bank_n;
    logic [12:0] mode_n, ext_n;
    assign cmd = cmd_t'({sd_RAS, sd_CAS, sd_WE});
    assign fire = sd_CKE && !sd_CS && cmd != CMD_NOP;
    assign cke_fall = cke_q && !sd_CKE && state != S_WAIT_CKE;
    assign init_st = state != S_WAIT_CKE && state != S_READY && state != S_FAIL;
    assign exp_ok = (state == S_PRE0 || state == S_PRE1) ? cmd == CMD_PRE && sd_A[10] :
                    state == S_EMRS ? cmd == CMD_LMR && sd_BA == 2'b01 :
                    (state == S_MRS0 || state == S_MRS1) ? cmd == CMD_LMR && sd_BA == 2'b00 :
                    (state == S_AR0 || state == S_AR1) && cmd == CMD_AR;
    ddr_gap_checker #(.tRP(tRP), .tMRD(tMRD), .tRFC(tRFC), .tRCD(tRCD)) u_gap (
        .clk133_p(clk133_p),
        .rst(rst),
        .fire(fire),
        .cmd(cmd),
        .viol(viol)
    );
    always_ff @(posedge clk133_p) begin
        if (rst) begin
            state <= S_WAIT_CKE;
            cke_q <= 1'b0;
            cmdValid <= 1'b0;
            cmdCode <= CMD_NOP;
            initDone <= 1'b0;
            modeReg <= '0;
            extModeReg <= '0;
            bankOpen <= '0;
            errTiming <= 1'b0;
            errSequence <= 1'b0;
            errCount <= '0;
        end else begin
            state <= state_n;
            cke_q <= sd_CKE;
            cmdValid <= fire;
            cmdCode <= fire ? cmd : CMD_NOP;
            initDone <= state_n == S_READY;
            modeReg <= mode_n;
            extModeReg <= ext_n;
            bankOpen <= bank_n;
            errTiming <= errTiming | viol;
            errSequence <= errSequence | seq_bad | cke_fall;
            errCount <= errCount + {7'd0, (viol || seq_bad) && errCount != 8'hFF};
        end
    end
    always_comb begin
        state_n = state;
        if (state == S_WAIT_CKE)
            state_n = sd_CKE ? S_PRE0 : S_WAIT_CKE;
        else if (cke_fall && state != S_READY)
            state_n = S_FAIL;
        else if (init_st && fire)
            state_n = exp_ok ? state_t'(state + 4'd1) : S_FAIL;
    end
    always_comb begin
        seq_bad = 1'b0;
        bank_n = bankOpen;
        mode_n = modeReg;
        ext_n = extModeReg;
        if (init_st && fire) begin
            seq_bad = !exp_ok;
            ext_n = exp_ok && state == S_EMRS ? sd_A : extModeReg;
            mode_n = exp_ok && (state == S_MRS0 || state == S_MRS1) ? sd_A : modeReg;
        end else if (state == S_READY && fire) begin
            case (cmd)
                CMD_ACT: begin
                    seq_bad = bankOpen[sd_BA];
                    bank_n[sd_BA] = 1'b1;
                end
                CMD_RD, CMD_WR, CMD_BST: seq_bad = !bankOpen[sd_BA];
                CMD_PRE: bank_n = sd_A[10] ? 4'b0 : bankOpen & ~(4'b1 << sd_BA);
                default: seq_bad = |bankOpen;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_cmd_monitor.sv
// tb_ddr_cmd_monitor: directed scenarios checked every cycle against a behavioural model
module tb_ddr_cmd_monitor;
    localparam logic [2:0] LMR = 3'd0, AR = 3'd1, PRE = 3'd2, ACT = 3'd3;
    localparam logic [2:0] WR = 3'd4, RD = 3'd5, BST = 3'd6, NOP = 3'd7;
    logic clk133_p = 0, rst = 1, sd_CKE = 0, sd_CS = 1, sd_RAS = 1, sd_CAS = 1, sd_WE = 1;
    logic [12:0] sd_A = 0;
    logic [1:0] sd_BA = 0;
    logic cmdValid, initDone, errTiming, errSequence;
    logic [2:0] cmdCode;
    logic [12:0] modeReg, extModeReg;
    logic [3:0] bankOpen;
    logic [7:0] errCount;
    int checks = 0, errors = 0;
    logic [2:0] exp_c [7] = '{PRE, LMR, LMR, PRE, AR, AR, LMR};
    logic [1:0] exp_ba [7] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    int phase, now = 0, last_t, e_cnt;
    logic [2:0] last_c, e_code;
    bit prev_cke, e_valid, e_init, e_et, e_es, chk_en = 0;
    bit open [4];
    logic [12:0] e_mode, e_ext;

    always #5 clk133_p = ~clk133_p;

    ddr_cmd_monitor dut (
        .clk133_p(clk133_p), .rst(rst), .sd_CKE(sd_CKE), .sd_CS(sd_CS),
        .sd_RAS(sd_RAS), .sd_CAS(sd_CAS), .sd_WE(sd_WE), .sd_A(sd_A), .sd_BA(sd_BA),
        .cmdValid(cmdValid), .cmdCode(cmdCode), .initDone(initDone), .modeReg(modeReg),
        .extModeReg(extModeReg), .bankOpen(bankOpen), .errTiming(errTiming),
        .errSequence(errSequence), .errCount(errCount)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic int need(input logic [2:0] c);
        return c == PRE ? 3 : c == LMR ? 2 : c == AR ? 11 : c == ACT ? 2 : 1;
    endfunction

    task automatic model();
        bit f, tbad, sbad, ok;
        logic [2:0] c;
        now++;
        if (rst) begin
            phase = -1; last_t = now - 100; last_c = NOP; prev_cke = 0;
            open = '{default: 0};
            e_valid = 0; e_code = NOP; e_init = 0; e_mode = 0; e_ext = 0;
            e_et = 0; e_es = 0; e_cnt = 0;
            return;
        end
        c = {sd_RAS, sd_CAS, sd_WE};
        f = sd_CKE && !sd_CS && c != NOP;
        tbad = f && (now - last_t < need(last_c));
        sbad = 0;
        if (phase < 0) begin
            if (sd_CKE) phase = 0;
        end else if (prev_cke && !sd_CKE) begin
            e_es = 1;
            if (phase < 7) phase = 8;
        end else if (f && phase < 7) begin
            ok = c == exp_c[phase] && (c == PRE ? sd_A[10] : c == LMR ? sd_BA == exp_ba[phase] : 1'b1);
            if (ok) begin
                if (phase == 1) e_ext = sd_A;
                if (phase == 2 || phase == 6) e_mode = sd_A;
                phase++;
            end else begin
                sbad = 1;
                phase = 8;
            end
        end else if (f && phase == 7) begin
            case (c)
                ACT: begin sbad = open[sd_BA]; open[sd_BA] = 1; end
                RD, WR, BST: sbad = !open[sd_BA];
                PRE: if (sd_A[10]) open = '{default: 0}; else open[sd_BA] = 0;
                default: sbad = open[0] | open[1] | open[2] | open[3];
            endcase
        end
        prev_cke = sd_CKE;
        e_et |= tbad;
        e_es |= sbad;
        if ((tbad || sbad) && e_cnt < 255) e_cnt++;
        e_valid = f;
        if (f) begin e_code = c; last_t = now; last_c = c; end
        e_init = phase == 7;
    endtask

    always @(negedge clk133_p) if (chk_en) begin
        chk("cmdValid", 32'(cmdValid), 32'(e_valid));
        if (e_valid) chk("cmdCode", 32'(cmdCode), 32'(e_code));
        chk("initDone", 32'(initDone), 32'(e_init));
        chk("modeReg", 32'(modeReg), 32'(e_mode));
        chk("extModeReg", 32'(extModeReg), 32'(e_ext));
        chk("bankOpen", 32'(bankOpen), 32'({open[3], open[2], open[1], open[0]}));
        chk("errTiming", 32'(errTiming), 32'(e_et));
        chk("errSequence", 32'(errSequence), 32'(e_es));
        chk("errCount", 32'(errCount), 32'(e_cnt));
    end

    task automatic cyc(input bit r, input bit cke, input bit cs, input logic [2:0] c,
                       input logic [12:0] a, input logic [1:0] ba);
        rst = r; sd_CKE = cke; sd_CS = cs; {sd_RAS, sd_CAS, sd_WE} = c; sd_A = a; sd_BA = ba;
        @(posedge clk133_p);
        model();
        @(negedge clk133_p);
    endtask

    task automatic cmd(input logic [2:0] c, input logic [12:0] a, input logic [1:0] ba, input int gap);
        cyc(0, 1, 0, c, a, ba);
        repeat (gap - 1) cyc(0, 1, 0, NOP, 13'd0, 2'd0);
    endtask

    task automatic reset_dut();
        repeat (2) cyc(1, 0, 1, NOP, 13'd0, 2'd0);
    endtask

    task automatic cke_up();
        repeat (2) cyc(0, 1, 1, NOP, 13'd0, 2'd0);
    endtask

    task automatic legal_init();
        cke_up();
        cmd(PRE, 13'h0400, 2'd0, 4);
        cmd(LMR, 13'h0000, 2'd1, 2);
        cmd(LMR, 13'h0021, 2'd0, 2);
        cmd(PRE, 13'h0400, 2'd0, 4);
        cmd(AR, 13'h0000, 2'd0, 11);
        cmd(AR, 13'h0000, 2'd0, 11);
        cmd(LMR, 13'h0021, 2'd0, 1);
        chk("initDone one cycle after MRS1", 32'(initDone), 32'd1);
        cyc(0, 1, 0, NOP, 13'd0, 2'd0);
    endtask

    initial begin
        chk_en = 1;
        reset_dut();
        chk("reset cmdCode", 32'(cmdCode), 32'h7);
        chk("reset errCount", 32'(errCount), 32'd0);
        chk("reset initDone", 32'(initDone), 32'd0);
        // legal init, then bank tracking in READY
        legal_init();
        chk("init modeReg", 32'(modeReg), 32'h21);
        chk("init extModeReg", 32'(extModeReg), 32'h0);
        chk("init errCount", 32'(errCount), 32'd0);
        cmd(ACT, 13'd0, 2'd2, 2);
        cmd(RD, 13'd0, 2'd1, 1);
        chk("rd closed errSequence", 32'(errSequence), 32'd1);
        chk("rd closed bankOpen", 32'(bankOpen), 32'h4);
        cmd(PRE, 13'h0400, 2'd0, 3);
        chk("pre all bankOpen", 32'(bankOpen), 32'h0);
        cmd(ACT, 13'd0, 2'd3, 2);
        cmd(WR, 13'd0, 2'd3, 1);
        cmd(ACT, 13'd0, 2'd3, 2);
        cmd(ACT, 13'd0, 2'd0, 2);
        cmd(PRE, 13'h0000, 2'd3, 3);
        chk("pre single bankOpen", 32'(bankOpen), 32'h1);
        cmd(LMR, 13'd0, 2'd0, 2);
        chk("lmr open errCount", 32'(errCount), 32'd3);
        cmd(PRE, 13'h0400, 2'd0, 3);
        cmd(AR, 13'd0, 2'd0, 11);
        cyc(0, 1, 1, LMR, 13'd0, 2'd0);
        repeat (300) cmd(PRE, 13'h0400, 2'd0, 1);
        chk("saturated errCount", 32'(errCount), 32'd255);
        repeat (2) cyc(0, 0, 1, NOP, 13'd0, 2'd0);
        chk("cke drop keeps initDone", 32'(initDone), 32'd1);
        // early EMRS: timing error only, order still accepted
        reset_dut();
        cke_up();
        cmd(PRE, 13'h0400, 2'd0, 1);
        cmd(LMR, 13'h0000, 2'd1, 2);
        chk("early emrs errTiming", 32'(errTiming), 32'd1);
        chk("early emrs errCount", 32'(errCount), 32'd1);
        cmd(LMR, 13'h0021, 2'd0, 2);
        cmd(PRE, 13'h0400, 2'd0, 4);
        cmd(AR, 13'd0, 2'd0, 11);
        cmd(AR, 13'd0, 2'd0, 11);
        cmd(LMR, 13'h0021, 2'd0, 1);
        chk("early emrs still ready", 32'(initDone), 32'd1);
        chk("early emrs errSequence", 32'(errSequence), 32'd0);
        // AR in place of EMRS
        reset_dut();
        cke_up();
        cmd(PRE, 13'h0400, 2'd0, 4);
        cmd(AR, 13'd0, 2'd0, 11);
        chk("wrong order errSequence", 32'(errSequence), 32'd1);
        cmd(LMR, 13'h0000, 2'd1, 2);
        cmd(LMR, 13'h0021, 2'd0, 2);
        chk("fail holds initDone", 32'(initDone), 32'd0);
        // reset after AR0 abandons the sequence
        reset_dut();
        cke_up();
        cmd(PRE, 13'h0400, 2'd0, 4);
        cmd(LMR, 13'h0004, 2'd1, 2);
        cmd(LMR, 13'h0033, 2'd0, 2);
        cmd(PRE, 13'h0400, 2'd0, 4);
        cmd(AR, 13'd0, 2'd0, 1);
        cyc(1, 1, 1, NOP, 13'd0, 2'd0);
        chk("mid reset modeReg", 32'(modeReg), 32'h0);
        chk("mid reset extModeReg", 32'(extModeReg), 32'h0);
        chk("mid reset cmdValid", 32'(cmdValid), 32'd0);
        legal_init();
        chk("reinit errCount", 32'(errCount), 32'd0);
        chk("reinit modeReg", 32'(modeReg), 32'h21);
        // CKE drop during init
        reset_dut();
        cke_up();
        cmd(PRE, 13'h0400, 2'd0, 4);
        cyc(0, 0, 1, NOP, 13'd0, 2'd0);
        chk("cke drop init errSequence", 32'(errSequence), 32'd1);
        cke_up();
        cmd(LMR, 13'h0000, 2'd1, 2);
        cmd(LMR, 13'h0021, 2'd0, 2);
        chk("cke drop init initDone", 32'(initDone), 32'd0);
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ddr_cmd_monitor.md
DDR_CMD_MONITOR -- requirements
Module: ddr_cmd_monitor

Interface
REQ-001 SHALL have parameters (name, default, meaning): tRP 3 precharge-to-next-command cycles; tMRD 2 load-mode-to-next-command cycles; tRFC 11 auto-refresh-to-next-command cycles; tRCD 2 activate-to-next-command cycles.
REQ-002 SHALL use one clock and a synchronous, active-high reset, with these ports (name direction width meaning): clk133_p in 1 clock, all inputs sampled on its rising edge; rst in 1 reset.
REQ-003 Ports: sd_CKE in 1; sd_CS in 1 active-low chip select; sd_RAS, sd_CAS, sd_WE in 1 each; sd_A in 13; sd_BA in 2. These are the DDR command-bus pins, observed as a responder.
REQ-004 Ports: cmdValid out 1 pulse per decoded non-NOP command; cmdCode out 3 {RAS,CAS,WE} of that command; initDone out 1; modeReg out 13; extModeReg out 13; bankOpen out 4.
REQ-005 Ports: errTiming out 1 sticky; errSequence out 1 sticky; errCount out 8 saturating.

Function
REQ-006 Decode rules: CKE=0 or CS=1 is idle. With CS=0, {RAS,CAS,WE} decodes as 000 LMR, 001 AR, 010 PRE, 011 ACT, 100 WR, 101 RD, 110 BST, 111 NOP.
REQ-007 All outputs are registered and reflect the command sampled on the previous edge, giving a latency of exactly 1 cycle.
REQ-008 Gap counter (4-bit) counts edges since the last non-NOP command, saturating at 15; it loads 1 on the edge after a non-NOP command.
REQ-009 Required gap by last command: PRE tRP; LMR tMRD; AR tRFC; ACT tRCD; all others 1. A non-NOP command arriving with gap < required gap sets errTiming.
REQ-010 Init FSM states: WAIT_CKE, PRE0, EMRS, MRS0, PRE1, AR0, AR1, MRS1, READY, FAIL.
REQ-011 Init FSM expectations: WAIT_CKE->PRE0 on the first edge with CKE=1. PRE0 expects PRE with A10=1. EMRS expects LMR with BA=01, which also loads extModeReg=sd_A. MRS0 expects LMR with BA=00, which also loads modeReg. PRE1 expects PRE with A10=1. AR0 and AR1 each expect AR. MRS1 expects LMR with BA=00, which reloads modeReg, then goes to READY and sets initDone=1.
REQ-012 During init, any non-NOP command other than the expected one sets errSequence and moves the FSM to FAIL. FAIL holds until reset, initDone stays 0, and decoding and timing checks continue.
REQ-013 Bank tracking in READY: ACT opens BA, and ACT to an already-open bank is a sequence error. RD/WR/BST to a closed bank is a sequence error. PRE with A10=1 closes all banks; PRE with A10=0 closes BA. AR with any bank open is a sequence error. LMR with any bank open is a sequence error.
REQ-014 CKE falling to 0 in any state other than WAIT_CKE sets errSequence. In that case the FSM goes to FAIL if initDone=0, otherwise the FSM stays in READY.
REQ-015 errCount increments once per offending command, even if the command causes both a timing and a sequence error, and saturates at 255.
REQ-016 cmdValid pulses for every non-NOP command, including erroneous ones.

Reset
REQ-017 On rst=1 at a rising edge, all outputs reset as follows: FSM=WAIT_CKE; gap counter=15; cmdValid=0; cmdCode=3'b111; initDone=0; modeReg=0; extModeReg=0; bankOpen=0; errTiming=0; errSequence=0; errCount=0.
REQ-018 rst asserted mid-sequence SHALL abandon the sequence with no partial state retained.

Structure
REQ-019 A shared package SHALL hold the 3-bit command encodings, the FSM state encodings, and the default timing constants, and the DDR controller SHALL use the same package.
REQ-020 One sub-module SHALL be used: ddr_gap_checker, containing the gap counter, the required-gap register, and the timing compare. The FSM and bank tracking stay in the top module.

Verification
REQ-021 Drive the legal init sequence with gaps of 4/2/2/4/11/11/2 cycles -> initDone=1 one cycle after MRS1, modeReg=13'h0021, extModeReg=0, no errors.
REQ-022 Issue EMRS 1 cycle after PRE0 with tRP=3 -> errTiming=1, errCount=1, FSM advances to MRS0 (order is correct).
REQ-023 Issue AR in place of EMRS -> errSequence=1, FSM=FAIL, initDone remains 0 after any further commands.
REQ-024 In READY: ACT BA=2, then RD BA=1 -> errSequence=1, bankOpen=4'b0100. Then PRE A10=1 -> bankOpen=0.
REQ-025 Assert rst mid-init after AR0 -> all outputs return to their reset values next cycle, and a full legal init afterwards completes cleanly.
REQ-026 Send 300 back-to-back timing violations -> errCount saturates at 255 without wrapping.
